// File: rtl/hamming_pkg.sv
// Shared SEC-DED Hamming helpers: code geometry and error classification,
// used by the decoder and the matching encoder.
package hamming_pkg;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_CORR,
        ERR_UNCORR
    } err_kind_e;

    // Smallest P with 2**P >= dataW + P + 1.
    function automatic int unsigned par_w(input int unsigned dataW);
        int unsigned p;
        p = 1;
        while ((32'd1 << p) < (dataW + p + 32'd1)) begin
            p = p + 1;
        end
        return p;
    endfunction

    function automatic logic is_pow2(input int unsigned pos);
        return (pos != 0) && ((pos & (pos - 32'd1)) == 0);
    endfunction

    // Position of data bit k: the k-th non-power-of-two position, counting from 3.
    function automatic int unsigned data_pos(input int unsigned k);
        int unsigned pos;
        pos = 2;
        for (int unsigned i = 0; i <= k; i++) begin
            pos = pos + 1;
            while (is_pow2(pos)) begin
                pos = pos + 1;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall parity of a SEC-DED Hamming codeword.
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter  int unsigned DATA_W = 8,
    localparam int unsigned PAR_W  = par_w(DATA_W),
    localparam int unsigned CW_W   = DATA_W + PAR_W + 1
) (
    input  logic [CW_W-1:0]  codeword,
    output logic [PAR_W-1:0] syndrome_c,
    output logic             overall_c
);

    // Syndrome bit k covers every position whose index has bit k set.
    always_comb begin
        syndrome_c = '0;
        for (int unsigned pos = 1; pos < CW_W; pos++) begin
            for (int unsigned k = 0; k < PAR_W; k++) begin
                if (pos[k]) begin
                    syndrome_c[k] = syndrome_c[k] ^ codeword[pos];
                end
            end
        end
    end

    assign overall_c = ^codeword;

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined SEC-DED Hamming decoder with valid/ready stream,
// per-word status and saturating error counters.
module hamming_secded_decoder
    import hamming_pkg::*;
#(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned CNT_W  = 16,
    localparam int unsigned PAR_W  = par_w(DATA_W),
    localparam int unsigned CW_W   = DATA_W + PAR_W + 1,
    localparam int unsigned POS_W  = PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   cw_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              err_corr,
    output logic              err_uncorr,
    output logic [POS_W-1:0]  err_pos,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    logic              s1Valid;
    logic [DATA_W-1:0] s1Data;
    logic [PAR_W-1:0]  s1Syn;
    logic              s1Ov;
    logic [DATA_W-1:0] s1DataNext;
    logic [PAR_W-1:0]  synC;
    logic              ovC;
    logic              adv2;
    logic              outFire;
    err_kind_e         kindC;
    logic [POS_W-1:0]  posC;
    logic [DATA_W-1:0] dataC;

    hamming_syndrome #(.DATA_W(DATA_W)) uSyndrome (
        .codeword   (cw_in),
        .syndrome_c (synC),
        .overall_c  (ovC)
    );

    assign adv2     = !out_valid || out_ready;
    assign in_ready = !s1Valid || adv2;
    assign outFire  = out_valid && out_ready;

    // Check bits are fully consumed by the syndrome, so stage 1 keeps only data positions.
    for (genvar k = 0; k < DATA_W; k++) begin : gData
        localparam int unsigned POS_K = data_pos(k);
        assign s1DataNext[k] = cw_in[POS_K];
        assign dataC[k]      = s1Data[k] ^ ((kindC == ERR_CORR) && (s1Syn == PAR_W'(POS_K)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid <= 1'b0;
            s1Data  <= '0;
            s1Syn   <= '0;
            s1Ov    <= 1'b0;
        end else if (in_valid && in_ready) begin
            s1Valid <= 1'b1;
            s1Data  <= s1DataNext;
            s1Syn   <= synC;
            s1Ov    <= ovC;
        end else if (adv2) begin
            s1Valid <= 1'b0;
        end
    end

    // Syndrome 0 with odd parity points at position 0: corrected, data untouched.
    always_comb begin
        kindC = ERR_NONE;
        posC  = '0;
        if (s1Ov) begin
            if (32'(s1Syn) < CW_W) begin
                kindC = ERR_CORR;
                posC  = POS_W'(s1Syn);
            end else begin
                kindC = ERR_UNCORR;
            end
        end else if (s1Syn != '0) begin
            kindC = ERR_UNCORR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            data_out   <= '0;
            err_corr   <= 1'b0;
            err_uncorr <= 1'b0;
            err_pos    <= '0;
        end else if (adv2) begin
            out_valid <= s1Valid;
            if (s1Valid) begin
                data_out   <= dataC;
                err_corr   <= (kindC == ERR_CORR);
                err_uncorr <= (kindC == ERR_UNCORR);
                err_pos    <= posC;
            end
        end
    end

    // Clear beats a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (outFire) begin
            if (err_corr && (corr_cnt != '1)) begin
                corr_cnt <= corr_cnt + CNT_W'(1);
            end
            if (err_uncorr && (uncorr_cnt != '1)) begin
                uncorr_cnt <= uncorr_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Self-checking bench for hamming_secded_decoder (DATA_W=8, CNT_W=4).
module tb_hamming_secded_decoder;

    localparam int unsigned DW   = 8;
    localparam int unsigned PW   = 4;
    localparam int unsigned CW   = 13;
    localparam int unsigned CNTW = 4;
    localparam int unsigned CMAX = 15;
    localparam int unsigned NV   = 10;

    typedef struct {
        logic [DW-1:0] data;
        logic          corr;
        logic          uncorr;
        logic [PW:0]   pos;
    } exp_t;

    typedef struct {
        logic [CW-1:0] cw;
        exp_t          e;
        int unsigned   corrCnt;
        int unsigned   uncorrCnt;
    } vec_t;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [CW-1:0]   cw_in;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   data_out;
    logic            err_corr;
    logic            err_uncorr;
    logic [PW:0]     err_pos;
    logic            cnt_clr;
    logic [CNTW-1:0] corr_cnt;
    logic [CNTW-1:0] uncorr_cnt;

    int          errors;
    int          checks;
    exp_t        sbQ[$];
    exp_t        pendExp;
    int unsigned mCorr;
    int unsigned mUncorr;
    vec_t        vecs[NV];
    logic [CW-1:0] t4cw[4];
    exp_t          t4exp[4];

    hamming_secded_decoder #(.DATA_W(DW), .CNT_W(CNTW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cw_in      (cw_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .err_corr   (err_corr),
        .err_uncorr (err_uncorr),
        .err_pos    (err_pos),
        .cnt_clr    (cnt_clr),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder: data on non-power-of-two positions, check bits chosen
    // so the XOR of all set-bit indices is zero, then overall even parity.
    function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
        logic [CW-1:0] cw;
        int k;
        int syn;
        cw = '0;
        k = 0;
        syn = 0;
        for (int p = 1; p < CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p] = d[k];
                k++;
            end
        end
        for (int p = 1; p < CW; p++) if (cw[p]) syn = syn ^ p;
        for (int b = 0; b < PW; b++) if (syn[b]) cw[1 << b] = 1'b1;
        cw[0] = ^cw[CW-1:1];
        return cw;
    endfunction

    function automatic logic [DW-1:0] extract(input logic [CW-1:0] cw);
        logic [DW-1:0] d;
        int k;
        d = '0;
        k = 0;
        for (int p = 1; p < CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[k] = cw[p];
                k++;
            end
        end
        return d;
    endfunction

    function automatic exp_t mkExp(input logic [DW-1:0] d, input logic c, input logic u, input int pos);
        exp_t e;
        e.data = d;
        e.corr = c;
        e.uncorr = u;
        e.pos = 5'(pos);
        return e;
    endfunction

    function automatic vec_t mkVec(input logic [CW-1:0] cw, input exp_t e, input int unsigned cc, input int unsigned uc);
        vec_t v;
        v.cw = cw;
        v.e = e;
        v.corrCnt = cc;
        v.uncorrCnt = uc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just before an active edge: scoreboards both handshakes and counters.
    task automatic clkStep(output logic acc);
        exp_t e;
        logic inFire;
        logic outFire;
        logic haveE;
        inFire  = in_valid && in_ready;
        outFire = out_valid && out_ready;
        haveE   = 1'b0;
        check("corr_cnt", 32'(corr_cnt), mCorr);
        check("uncorr_cnt", 32'(uncorr_cnt), mUncorr);
        if (outFire) begin
            if (sbQ.size() == 0) begin
                check("spurious out_valid", 32'(out_valid), 0);
            end else begin
                e = sbQ.pop_front();
                haveE = 1'b1;
                check("sb data_out", 32'(data_out), 32'(e.data));
                check("sb err_corr", 32'(err_corr), 32'(e.corr));
                check("sb err_uncorr", 32'(err_uncorr), 32'(e.uncorr));
                check("sb err_pos", 32'(err_pos), 32'(e.pos));
            end
        end
        if (cnt_clr) begin
            mCorr = 0;
            mUncorr = 0;
        end else if (haveE) begin
            if (e.corr && mCorr < CMAX) mCorr++;
            if (e.uncorr && mUncorr < CMAX) mUncorr++;
        end
        if (inFire) sbQ.push_back(pendExp);
        acc = inFire;
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        logic a;
        clkStep(a);
    endtask

    task automatic drain(input string name);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cnt_clr = 1'b0;
        for (int i = 0; i < 20 && sbQ.size() > 0; i++) begin
            #1;
            tick();
        end
        check({name, " drained"}, 32'(sbQ.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          acc;
        logic [DW-1:0] d;
        logic [CW-1:0] curCw;
        logic          haveWord;
        int            nf;
        int            p0;
        int            p1;
        int            n;
        int            idx;

        errors = 0;
        checks = 0;
        mCorr = 0;
        mUncorr = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        cw_in = '0;
        cnt_clr = 1'b0;

        vecs[0] = mkVec(13'h144E, mkExp(8'hA5, 1'b0, 1'b0, 0), 0, 0);
        vecs[1] = mkVec(13'h146E, mkExp(8'hA5, 1'b1, 1'b0, 5), 1, 0);
        vecs[2] = mkVec(13'h144F, mkExp(8'hA5, 1'b1, 1'b0, 0), 2, 0);
        vecs[3] = mkVec(13'h106E, mkExp(8'h87, 1'b0, 1'b1, 0), 2, 1);
        vecs[4] = mkVec(13'h1C4E, mkExp(8'hA5, 1'b1, 1'b0, 11), 3, 1);
        vecs[5] = mkVec(13'h044E, mkExp(8'hA5, 1'b1, 1'b0, 12), 4, 1);
        vecs[6] = mkVec(13'h1448, mkExp(8'hA5, 1'b0, 1'b1, 0), 4, 2);
        vecs[7] = mkVec(13'h0448, mkExp(8'h25, 1'b0, 1'b1, 0), 4, 3);
        vecs[8] = mkVec(13'h1EEE, mkExp(8'hFF, 1'b0, 1'b0, 0), 4, 3);
        vecs[9] = mkVec(13'h1EE6, mkExp(8'hFF, 1'b1, 1'b0, 3), 5, 3);

        // Reset state
        #12;
        check("rst out_valid", 32'(out_valid), 0);
        check("rst data_out", 32'(data_out), 0);
        check("rst err_corr", 32'(err_corr), 0);
        check("rst err_uncorr", 32'(err_uncorr), 0);
        check("rst err_pos", 32'(err_pos), 0);
        check("rst corr_cnt", 32'(corr_cnt), 0);
        check("rst uncorr_cnt", 32'(uncorr_cnt), 0);
        check("rst in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed vectors, one word at a time
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1;
            cw_in = vecs[i].cw;
            out_ready = 1'b1;
            pendExp = vecs[i].e;
            #1;
            clkStep(acc);
            check("vec accepted", 32'(acc), 1);
            in_valid = 1'b0;
            #1;
            check("vec latency out_valid", 32'(out_valid), 0);
            tick();
            #1;
            check("vec out_valid", 32'(out_valid), 1);
            check("vec data_out", 32'(data_out), 32'(vecs[i].e.data));
            check("vec err_corr", 32'(err_corr), 32'(vecs[i].e.corr));
            check("vec err_uncorr", 32'(err_uncorr), 32'(vecs[i].e.uncorr));
            check("vec err_pos", 32'(err_pos), 32'(vecs[i].e.pos));
            tick();
            check("vec corr_cnt", 32'(corr_cnt), vecs[i].corrCnt);
            check("vec uncorr_cnt", 32'(uncorr_cnt), vecs[i].uncorrCnt);
        end

        // Back-pressure: four back-to-back words, out_ready low for cycles 3..6
        for (int i = 0; i < 4; i++) begin
            d = 8'((i + 1) * 8'h11);
            t4cw[i] = encode(d);
            t4exp[i] = mkExp(d, 1'b0, 1'b0, 0);
        end
        t4cw[1] = t4cw[1] ^ 13'h0080;
        t4exp[1] = mkExp(8'h22, 1'b1, 1'b0, 7);
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = (idx < 4);
            cw_in = t4cw[idx % 4];
            pendExp = t4exp[idx % 4];
            out_ready = !(c >= 3 && c <= 6);
            #1;
            if (c == 3) check("bp in_ready full", 32'(in_ready), 0);
            if (c >= 3 && c <= 6) begin
                check("bp out_valid held", 32'(out_valid), 1);
                check("bp data_out held", 32'(data_out), 32'(t4exp[1].data));
                check("bp err_corr held", 32'(err_corr), 1);
                check("bp err_pos held", 32'(err_pos), 7);
            end
            clkStep(acc);
            if (acc) idx++;
        end
        check("bp words accepted", 32'(idx), 4);
        drain("bp");

        // Saturation then clear-wins-over-increment
        cnt_clr = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        tick();
        cnt_clr = 1'b0;
        n = 0;
        for (int c = 0; c < 40 && n < 17; c++) begin
            d = 8'(n * 7);
            in_valid = 1'b1;
            cw_in = encode(d) ^ (13'(1) << (n % CW));
            pendExp = mkExp(d, 1'b1, 1'b0, n % CW);
            #1;
            clkStep(acc);
            if (acc) n++;
        end
        check("sat words sent", 32'(n), 17);
        drain("sat");
        check("corr_cnt saturated", 32'(corr_cnt), 15);
        in_valid = 1'b1;
        cw_in = encode(8'h3C) ^ 13'h0020;
        pendExp = mkExp(8'h3C, 1'b1, 1'b0, 5);
        out_ready = 1'b0;
        #1;
        tick();
        in_valid = 1'b0;
        #1;
        tick();
        out_ready = 1'b1;
        cnt_clr = 1'b1;
        #1;
        check("clr cycle out_valid", 32'(out_valid), 1);
        tick();
        cnt_clr = 1'b0;
        check("clr wins corr_cnt", 32'(corr_cnt), 0);

        // Random traffic with 0/1/2 injected bit errors
        haveWord = 1'b0;
        curCw = '0;
        for (int c = 0; c < 400; c++) begin
            if (!haveWord) begin
                d = 8'($urandom);
                nf = int'($urandom_range(0, 2));
                p0 = int'($urandom_range(0, CW - 1));
                do p1 = int'($urandom_range(0, CW - 1)); while (p1 == p0);
                curCw = encode(d);
                pendExp = mkExp(d, 1'b0, 1'b0, 0);
                if (nf == 1) begin
                    curCw[p0] = ~curCw[p0];
                    pendExp = mkExp(d, 1'b1, 1'b0, p0);
                end else if (nf == 2) begin
                    curCw[p0] = ~curCw[p0];
                    curCw[p1] = ~curCw[p1];
                    pendExp = mkExp(extract(curCw), 1'b0, 1'b1, 0);
                end
                haveWord = 1'b1;
            end
            in_valid = haveWord && ($urandom_range(0, 9) < 7);
            cw_in = curCw;
            out_ready = ($urandom_range(0, 9) < 7);
            cnt_clr = ($urandom_range(0, 49) == 0);
            #1;
            clkStep(acc);
            if (acc) haveWord = 1'b0;
        end
        drain("random");

        // Asynchronous reset with two words in flight
        in_valid = 1'b1;
        cw_in = encode(8'h5A) ^ 13'h0200;
        pendExp = mkExp(8'h5A, 1'b1, 1'b0, 9);
        #1;
        tick();
        drain("pre-reset");
        check("pre-reset corr_cnt nonzero", 32'(corr_cnt != 0), 1);
        in_valid = 1'b1;
        out_ready = 1'b0;
        cw_in = encode(8'h01);
        pendExp = mkExp(8'h01, 1'b0, 1'b0, 0);
        #1;
        tick();
        cw_in = encode(8'h02);
        pendExp = mkExp(8'h02, 1'b0, 1'b0, 0);
        #1;
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", 32'(out_valid), 0);
        check("async rst corr_cnt", 32'(corr_cnt), 0);
        check("async rst uncorr_cnt", 32'(uncorr_cnt), 0);
        check("async rst data_out", 32'(data_out), 0);
        check("async rst in_ready", 32'(in_ready), 1);
        sbQ.delete();
        mCorr = 0;
        mUncorr = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("post-reset no stale word", 32'(out_valid), 0);
            check("post-reset in_ready", 32'(in_ready), 1);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hamming_secded_decoder.md
Name: hamming_secded_decoder

Overview:
- Parametrised, pipelined SEC-DED Hamming decoder. Generalises the fixed 12/8 single-error-correcting decoder to any data width.
- Adds an overall-parity bit for double-error detection, a valid/ready stream handshake, per-word status and saturating error counters.
- Sits on the receive side of a link or memory read path, fed by the matching encoder.

Parameters:
- DATA_W, 8: data bits per word (>= 4).
- PAR_W, derived: smallest P with 2**P >= DATA_W+P+1. Equals 4 for DATA_W=8.
- CW_W, derived: DATA_W+PAR_W+1, the codeword width including the overall parity bit.
- CNT_W, 16: width of the error counters.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  codeword valid.
- in_ready  out  1  decoder can accept a codeword.
- cw_in  in  CW_W  codeword; bit i is Hamming position i.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- data_out  out  DATA_W  corrected data.
- err_corr  out  1  single error corrected; data_out is valid.
- err_uncorr  out  1  uncorrectable error; data_out is raw and unreliable.
- err_pos  out  PAR_W+1  position of the corrected bit, 0 when none; width fits values up to CW_W-1.
- cnt_clr  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_W  count of corrected words, saturating.
- uncorr_cnt  out  CNT_W  count of uncorrectable words, saturating.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. The reset state of all outputs is 0: out_valid, data_out, err_*, and both counters. in_ready is 1 out of reset.
- Codeword layout:
  - Position 0 holds overall even parity over positions 1..CW_W-1.
  - Powers-of-two positions hold check bits.
  - data bit k (k from 0) maps to the k-th non-power-of-two position, ascending (bit 0 at position 3).
- Stage 1 (on input handshake): register cw_in, the syndrome s (PAR_W bits) and ov = XOR of all CW_W bits.
  - s bit k = XOR of all positions 1..CW_W-1 whose index has bit k set.
- Stage 2 (on transfer into stage 2): classify the word, correct it and register the results.
  - s=0, ov=0: clean. err_corr=0, err_uncorr=0, err_pos=0.
  - ov=1, s=0: error in position 0. err_corr=1, err_pos=0, data unchanged.
  - ov=1, 1 <= s <= CW_W-1: flip bit s. err_corr=1, err_pos=s.
  - ov=1, s > CW_W-1 (not possible when the position range is full): err_uncorr=1.
  - ov=0, s != 0: double error. err_uncorr=1, no flip, err_pos=0.
- Pipeline control:
  - adv2 = !out_valid || out_ready.
  - Stage 1 moves into stage 2 when s1_valid && adv2.
  - in_ready = !s1_valid || adv2. This is combinational from out_ready.
  - Latency is 2 cycles from the input handshake to out_valid with no back-pressure. Full throughput is 1 word per cycle.
  - Under back-pressure, output data and status hold stable while out_valid && !out_ready. No word is lost or duplicated.
- Counters:
  - Increment on the output handshake (out_valid && out_ready), by the status of the word transferred.
  - Both counters saturate at 2**CNT_W-1.
  - cnt_clr zeroes both counters and wins over a same-cycle increment.
- Reset mid-stream: all in-flight words are discarded, valids clear and counters clear.
- Outputs are registered except in_ready.

Decomposition:
- Shared package hamming_pkg holds:
  - function par_w(data_w);
  - function is_pow2(pos);
  - function data_pos(k), which maps a data index to its position;
  - typedef err_kind_e {ERR_NONE, ERR_CORR, ERR_UNCORR}.
  The matching encoder reuses these.
- One sub-module, hamming_syndrome: combinational. Takes a codeword and returns s and ov. It is shared with the future encoder self-check.

Test Plan (DATA_W=8, CW_W=13; clean codeword for 0xA5 is 0x144E):
1. cw_in=0x144E, out_ready=1 -> after 2 cycles data_out=0xA5, err_corr=0, err_uncorr=0, err_pos=0; counters stay 0.
2. cw_in=0x146E (bit 5 flipped) -> data_out=0xA5, err_corr=1, err_pos=5, corr_cnt=1. Then cw_in=0x144F (bit 0 flipped) -> data_out=0xA5, err_corr=1, err_pos=0, corr_cnt=2.
3. cw_in=0x106E (bits 5 and 10 flipped) -> err_uncorr=1, err_corr=0, uncorr_cnt=1.
4. Stream 4 back-to-back words with out_ready held 0 for cycles 3-6 -> in_ready=0 once both stages are full. The output word is held stable, then all 4 words emerge in order with no loss.
5. Preset corr_cnt near saturation (CNT_W=4 build, 16 corrected words) -> corr_cnt stops at 15. Assert cnt_clr in the same cycle as a corrected handshake -> corr_cnt=0.
6. Assert rst_n=0 asynchronously with 2 words in flight -> out_valid=0 and counters=0 immediately, in_ready=1 after release, and no stale word is output.
